rb_read_scheduler: RTL and testbench
====================================

RB_READ_SCHEDULER -- requirements
Module: rb_read_scheduler

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 64, pixels per row; a multiple of 4, at most 512.
REQ-002 The block SHALL have parameter NUM_ROWS, default 4, row slots in the BRAM ring; at least 3, and NUM_ROWS*IMG_WIDTH at most 2048.
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 Ports (in order, after clk and rst_n):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- clear  in  1  synchronous flush of all counters and pointers
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  input pixel accept
- pix_data  in  8  pixel byte
- mem_en_a  out  1  BRAM port-A write enable
- mem_addr_a  out  11  BRAM byte address
- mem_din_a  out  8  BRAM write byte
- mem_en_b  out  1  BRAM port-B read enable
- mem_addr_b  out  9  BRAM word address
- mem_dout_b  in  32  BRAM read word
- win_valid  out  1  window column-group valid
- win_ready  in  1  window accept
- win_data  out  96  {row2, row1, row0} words; row0 is the oldest row, at [31:0]
- win_col  out  7  word index within the row
- row_done  out  1  one-cycle pulse on row write completion

Function
REQ-005 A pixel SHALL transfer on a cycle where pix_valid and pix_ready are both high; in that cycle mem_en_a=1, mem_addr_a=wr_slot*IMG_WIDTH+wr_col, and mem_din_a=pix_data (combinational).
REQ-006 wr_col SHALL increment per transfer; at IMG_WIDTH-1 it SHALL wrap to 0, wr_slot SHALL advance modulo NUM_ROWS, and row_done SHALL pulse in the following cycle.
REQ-007 rows_avail (completed rows not yet released) SHALL be maintained as follows:
- increment on row completion
- decrement on release
- unchanged when both occur in the same cycle
REQ-008 pix_ready SHALL be high when rows_avail < NUM_ROWS, and low otherwise.
REQ-009 Byte packing SHALL be little-endian: BRAM word w holds bytes 4w..4w+3, with byte 4w at [7:0].
REQ-010 The read FSM SHALL have states IDLE, FETCH, DRAIN, PRESENT and RELEASE.
REQ-011 IDLE SHALL go to FETCH when rows_avail >= 3.
REQ-012 FETCH SHALL issue three consecutive reads, mem_en_b=1 and mem_addr_b=((rd_slot+k) mod NUM_ROWS)*(IMG_WIDTH/4)+rd_word for k=0,1,2, then go to DRAIN.
REQ-013 Read latency SHALL be 1 cycle: mem_dout_b SHALL be captured into win_data lane k one cycle after read k is issued.
REQ-014 DRAIN SHALL last 1 cycle (capture of lane 2), then go to PRESENT.
REQ-015 In PRESENT, win_valid=1, and win_data and win_col SHALL hold stable until win_ready=1; on accept:
- if rd_word < IMG_WIDTH/4-1: increment rd_word and go to FETCH
- else: go to RELEASE
REQ-016 RELEASE SHALL last 1 cycle: rd_word=0, rd_slot advances modulo NUM_ROWS, rows_avail decrements, then go to IDLE.
REQ-017 The minimum throughput SHALL be one window per 5 cycles.
REQ-018 mem_en_b SHALL be 0 outside FETCH.
REQ-019 clear SHALL zero all of the following:
- wr_col, wr_slot, rd_slot, rd_word, rows_avail
- FSM (returns to IDLE)
- win_valid, row_done
REQ-020 clear SHALL take priority over a simultaneous pixel transfer, which is dropped.

Reset
REQ-021 On rst_n=0, all state SHALL clear asynchronously to the same values as clear, and the FSM SHALL enter IDLE.
REQ-022 Outputs during reset SHALL be:
- pix_ready=1
- mem_en_a=0, mem_en_b=0, mem_addr_a=0, mem_addr_b=0
- win_valid=0, win_data=0, win_col=0, row_done=0
REQ-023 Reset asserted mid-FETCH SHALL abandon the fetch; no win_valid pulse SHALL follow deassertion.

Structure
REQ-024 Shared package rb_pkg SHALL hold:
- constants ADDR_A_W=11, ADDR_B_W=9, DIN_W=8, DOUT_W=32, WIN_ROWS=3
- the read-FSM state enum
REQ-025 Write-side counting SHALL be a sub-module, rb_wr_addr_gen, owning wr_col, wr_slot, row_done and mem_addr_a.
REQ-026 The block SHALL NOT instantiate the BRAM; a top level connects it.

Verification
Parameters for all scenarios: IMG_WIDTH=16, NUM_ROWS=4; BRAM model with 1-cycle read latency.
REQ-027 Stream pixel value = index (0..47), win_ready=1 -> first window win_col=0 with:
- win_data[31:0]=0x03020100
- win_data[63:32]=0x13121110
- win_data[95:64]=0x23222120
REQ-028 Stream 48 pixels with win_ready=1 -> exactly four windows (win_col 0..3) follow, then RELEASE, then rows_avail=2.
REQ-029 win_ready=0 permanently while streaming -> the following occur:
- win_data/win_col stay stable
- pix_ready falls after pixel 63
- no write targets slots 0-2
REQ-030 Stream 80 pixels with win_ready=1 -> pixels 64..79 write mem_addr_a 0..15 (wrap), and the second row-set window reads slots 1,2,3.
REQ-031 clear asserted in PRESENT, simultaneous with pix_valid -> next cycle:
- win_valid=0, FSM in IDLE
- that pixel is not written
- the next pixel writes mem_addr_a=0
REQ-032 rst_n low for 1 cycle during FETCH -> all outputs at reset values; no win_valid until 3 new rows are written.

Source files
------------

// File: rtl/rb_pkg.sv
// rb_pkg: shared widths and read-FSM state encoding for the row-buffer read scheduler
package rb_pkg;
   localparam int ADDR_A_W = 11;
   localparam int ADDR_B_W = 9;
   localparam int DIN_W    = 8;
   localparam int DOUT_W   = 32;
   localparam int WIN_ROWS = 3;
   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, RELEASE} rd_state_t;
endpackage

// File: rtl/rb_wr_addr_gen.sv
// rb_wr_addr_gen: write-side column/slot counters and BRAM byte address for the row ring
// Ports: clk/rst_n clock and async reset; clear sync flush; xfer accepted pixel;
//   row_end combinational last-pixel-of-row flag; row_done registered completion pulse;
//   mem_addr_a byte address of the current write position
module rb_wr_addr_gen
   import rb_pkg::*;
#(
   parameter int IMG_WIDTH = 64,
   parameter int NUM_ROWS  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                xfer,
   output logic                row_end,
   output logic                row_done,
   output logic [ADDR_A_W-1:0] mem_addr_a
);
   localparam int SW = $clog2(NUM_ROWS);
   logic [8:0]    wr_col;
   logic [SW-1:0] wr_slot;
   assign row_end    = xfer && wr_col == 9'(IMG_WIDTH - 1);
   assign mem_addr_a = ADDR_A_W'(wr_slot) * ADDR_A_W'(IMG_WIDTH) + ADDR_A_W'(wr_col);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_col   <= '0;
         wr_slot  <= '0;
         row_done <= 1'b0;
      end else if (clear) begin
         wr_col   <= '0;
         wr_slot  <= '0;
         row_done <= 1'b0;
      end else begin
         row_done <= row_end;
         if (xfer) wr_col <= row_end ? '0 : wr_col + 9'd1;
         if (row_end) wr_slot <= wr_slot == SW'(NUM_ROWS - 1) ? '0 : wr_slot + SW'(1);
      end
   end
endmodule

// File: rtl/rb_read_scheduler.sv
// rb_read_scheduler: fills a BRAM row ring with pixels and reads back 3-row word windows
// Ports: clk/rst_n clock and async reset; clear sync flush; pix_* pixel input stream;
//   mem_*_a BRAM byte write port; mem_*_b BRAM word read port (1-cycle latency);
//   win_* window stream {row2,row1,row0} with row0 oldest; row_done pulse per written row
module rb_read_scheduler
   import rb_pkg::*;
#(
   parameter int IMG_WIDTH = 64,
   parameter int NUM_ROWS  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         pix_valid,
   output logic                         pix_ready,
   input  logic [DIN_W-1:0]             pix_data,
   output logic                         mem_en_a,
   output logic [ADDR_A_W-1:0]          mem_addr_a,
   output logic [DIN_W-1:0]             mem_din_a,
   output logic                         mem_en_b,
   output logic [ADDR_B_W-1:0]          mem_addr_b,
   input  logic [DOUT_W-1:0]            mem_dout_b,
   output logic                         win_valid,
   input  logic                         win_ready,
   output logic [WIN_ROWS*DOUT_W-1:0]   win_data,
   output logic [6:0]                   win_col,
   output logic                         row_done
);
   localparam int WORDS = IMG_WIDTH / 4;
   localparam int SW    = $clog2(NUM_ROWS);
   localparam int RW    = $clog2(NUM_ROWS + 1);
   rd_state_t         state, state_nx;
   logic [1:0]        k, cap_k;
   logic              cap_en, row_end, release_row, last_word, accept;
   logic [SW-1:0]     rd_slot, fetch_slot;
   logic [SW:0]       slot_sum;
   logic [6:0]        rd_word;
   logic [RW-1:0]     rows_avail;
   logic [DOUT_W-1:0] lane [WIN_ROWS];
   assign pix_ready   = rows_avail < RW'(NUM_ROWS);
   assign mem_en_a    = pix_valid && pix_ready && !clear;
   assign mem_din_a   = pix_data;
   assign release_row = state == RELEASE;
   assign last_word   = rd_word == 7'(WORDS - 1);
   assign accept      = state == PRESENT && win_ready;
   assign win_col     = rd_word;
   assign win_data    = {lane[2], lane[1], lane[0]};
   // Lane k reads the k-th oldest row of the window, wrapping around the ring.
   assign slot_sum    = {1'b0, rd_slot} + {{(SW - 1){1'b0}}, k};
   assign fetch_slot  = slot_sum >= (SW + 1)'(NUM_ROWS) ? SW'(slot_sum - (SW + 1)'(NUM_ROWS)) : SW'(slot_sum);
   assign mem_addr_b  = mem_en_b ? ADDR_B_W'(fetch_slot) * ADDR_B_W'(WORDS) + ADDR_B_W'(rd_word) : '0;
   rb_wr_addr_gen #(.IMG_WIDTH(IMG_WIDTH), .NUM_ROWS(NUM_ROWS)) u_wr (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .xfer       (mem_en_a),
      .row_end    (row_end),
      .row_done   (row_done),
      .mem_addr_a (mem_addr_a)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= clear ? IDLE : state_nx;
   end
   always_comb begin
      state_nx  = state;
      mem_en_b  = 1'b0;
      win_valid = 1'b0;
      case (state)
         IDLE:    state_nx = rows_avail >= RW'(WIN_ROWS) ? FETCH : IDLE;
         FETCH: begin
            mem_en_b = 1'b1;
            state_nx = k == 2'd2 ? DRAIN : FETCH;
         end
         DRAIN:   state_nx = PRESENT;
         PRESENT: begin
            win_valid = 1'b1;
            state_nx  = win_ready ? (last_word ? RELEASE : FETCH) : PRESENT;
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k          <= '0;
         cap_k      <= '0;
         cap_en     <= 1'b0;
         rd_slot    <= '0;
         rd_word    <= '0;
         rows_avail <= '0;
         for (int i = 0; i < WIN_ROWS; i++) lane[i] <= '0;
      end else if (clear) begin
         k          <= '0;
         cap_en     <= 1'b0;
         rd_slot    <= '0;
         rd_word    <= '0;
         rows_avail <= '0;
      end else begin
         k          <= (state == FETCH && k != 2'd2) ? k + 2'd1 : 2'd0;
         // Read data returns one cycle after issue, so the lane index is delayed alongside it.
         cap_en     <= mem_en_b;
         cap_k      <= k;
         if (cap_en) lane[cap_k] <= mem_dout_b;
         if (release_row) rd_word <= '0;
         else if (accept && !last_word) rd_word <= rd_word + 7'd1;
         if (release_row) rd_slot <= rd_slot == SW'(NUM_ROWS - 1) ? '0 : rd_slot + SW'(1);
         rows_avail <= rows_avail + RW'(row_end) - RW'(release_row);
      end
   end
endmodule

// File: tb/tb_rb_read_scheduler.sv
// tb_rb_read_scheduler: directed self-checking bench with a 1-cycle-latency BRAM model
module tb_rb_read_scheduler;
   import rb_pkg::*;
   logic        clk = 0, rst_n = 0, clear = 0, pix_valid = 0, win_ready = 0;
   logic        pix_ready, mem_en_a, mem_en_b, win_valid, row_done;
   logic [7:0]  pix_data = 0, mem_din_a;
   logic [10:0] mem_addr_a;
   logic [8:0]  mem_addr_b;
   logic [31:0] mem_dout_b;
   logic [95:0] win_data;
   logic [6:0]  win_col;
   logic [7:0]  bram [2048];
   int vectors = 0, miscompares = 0;
   int pix_idx = 0, npix = 0, cyc = 0, rows_seen = 0, unstable = 0;
   logic prev_v = 0, prev_acc = 0, found;
   logic [95:0] prev_d;
   logic [6:0]  prev_c;
   logic [95:0] wdat[$];
   int wcol[$], wcyc[$], waddr[$], wdin[$];
   localparam logic [95:0] FIRST_WIN = {32'h23222120, 32'h13121110, 32'h03020100};

   rb_read_scheduler #(.IMG_WIDTH(16), .NUM_ROWS(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .mem_en_a(mem_en_a), .mem_addr_a(mem_addr_a), .mem_din_a(mem_din_a),
      .mem_en_b(mem_en_b), .mem_addr_b(mem_addr_b), .mem_dout_b(mem_dout_b),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .win_col(win_col),
      .row_done(row_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en_a) bram[mem_addr_a] <= mem_din_a;
      if (mem_en_b) mem_dout_b <= {bram[{mem_addr_b, 2'd3}], bram[{mem_addr_b, 2'd2}],
                                   bram[{mem_addr_b, 2'd1}], bram[{mem_addr_b, 2'd0}]};
   end

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_log();
      wdat.delete(); wcol.delete(); wcyc.delete(); waddr.delete(); wdin.delete();
      rows_seen = 0; unstable = 0; prev_v = 0; prev_acc = 0; pix_idx = 0; npix = 0;
   endtask

   task automatic pulse_reset();
      pix_valid = 0;
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      clr_log();
   endtask

   // Observe at the falling edge, drive new inputs just after the rising edge.
   task automatic run(input int ncyc);
      pix_valid = pix_idx < npix;
      pix_data  = 8'(pix_idx);
      for (int c = 0; c < ncyc; c++) begin
         logic took;
         @(negedge clk);
         cyc++;
         if (win_valid && win_ready) begin
            wdat.push_back(win_data); wcol.push_back(int'(win_col)); wcyc.push_back(cyc);
         end
         if (win_valid && prev_v && !prev_acc && (win_data !== prev_d || win_col !== prev_c)) unstable++;
         prev_v = win_valid; prev_acc = win_ready; prev_d = win_data; prev_c = win_col;
         if (mem_en_a) begin waddr.push_back(int'(mem_addr_a)); wdin.push_back(int'(mem_din_a)); end
         if (row_done) rows_seen++;
         took = mem_en_a;
         @(posedge clk); #1;
         if (took) pix_idx++;
         pix_valid = pix_idx < npix;
         pix_data  = 8'(pix_idx);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctl"}, 96'({pix_ready, mem_en_a, mem_en_b, win_valid, row_done}), 96'(5'b10000));
      chk({tag, "_addr_a"}, 96'(mem_addr_a), 96'(0));
      chk({tag, "_addr_b"}, 96'(mem_addr_b), 96'(0));
      chk({tag, "_win_data"}, win_data, 96'(0));
      chk({tag, "_win_col"}, 96'(win_col), 96'(0));
   endtask

   initial begin
      #12;
      chk_reset_outs("por");
      @(posedge clk); #1;
      rst_n = 1;
      clr_log();

      // Three rows then four windows over slots 0,1,2.
      win_ready = 1; npix = 48;
      run(90);
      chk("a_win_count", 96'(wdat.size()), 96'(4));
      chk("a_first_win", wdat[0], FIRST_WIN);
      chk("a_first_col", 96'(wcol[0]), 96'(0));
      chk("a_last_col", 96'(wcol[3]), 96'(3));
      chk("a_last_win", wdat[3], {32'h2f2e2d2c, 32'h1f1e1d1c, 32'h0f0e0d0c});
      chk("a_throughput", 96'(wcyc[1] - wcyc[0]), 96'(5));
      chk("a_rows_done", 96'(rows_seen), 96'(3));
      chk("a_rows_avail", 96'(dut.rows_avail), 96'(2));
      chk("a_idle", 96'(dut.state), 96'(IDLE));

      // Continue to 80 pixels: ring wrap and row sets {1,2,3} and {2,3,0}.
      npix = 80;
      run(150);
      chk("b_win_count", 96'(wdat.size()), 96'(12));
      chk("b_set2_win0", wdat[4], {32'h33323130, 32'h23222120, 32'h13121110});
      chk("b_set3_win0", wdat[8], {32'h43424140, 32'h33323130, 32'h23222120});
      chk("b_set3_win3", wdat[11], {32'h4f4e4d4c, 32'h3f3e3d3c, 32'h2f2e2d2c});
      chk("b_set3_col3", 96'(wcol[11]), 96'(3));
      chk("b_addr_63", 96'(waddr[63]), 96'(63));
      chk("b_addr_64", 96'(waddr[64]), 96'(0));
      chk("b_addr_79", 96'(waddr[79]), 96'(15));
      chk("b_din_79", 96'(wdin[79]), 96'(79));
      chk("b_rows_done", 96'(rows_seen), 96'(5));
      chk("b_rows_avail", 96'(dut.rows_avail), 96'(2));

      // Back-pressure: window held, input stalls once the ring is full.
      pulse_reset();
      win_ready = 0; npix = 80;
      run(120);
      chk("c_writes", 96'(waddr.size()), 96'(64));
      chk("c_addr_48", 96'(waddr[48]), 96'(48));
      chk("c_pix_ready", 96'(pix_ready), 96'(0));
      chk("c_win_valid", 96'(win_valid), 96'(1));
      chk("c_win_data", win_data, FIRST_WIN);
      chk("c_win_col", 96'(win_col), 96'(0));
      chk("c_stable", 96'(unstable), 96'(0));
      chk("c_no_accept", 96'(wdat.size()), 96'(0));

      // clear while presenting, with a pixel offered in the same cycle.
      pulse_reset();
      win_ready = 0; npix = 48;
      run(80);
      chk("d_present", 96'(win_valid), 96'(1));
      clear = 1; pix_valid = 1; pix_data = 8'hAA;
      @(negedge clk);
      chk("d_clear_no_write", 96'(mem_en_a), 96'(0));
      @(posedge clk); #1;
      clear = 0; pix_data = 8'h55;
      @(negedge clk);
      chk("d_win_valid", 96'(win_valid), 96'(0));
      chk("d_idle", 96'(dut.state), 96'(IDLE));
      chk("d_bram0_kept", 96'(bram[0]), 96'(0));
      chk("d_next_en", 96'(mem_en_a), 96'(1));
      chk("d_next_addr", 96'(mem_addr_a), 96'(0));
      @(posedge clk); #1;
      pix_valid = 0;

      // Reset during FETCH abandons the window.
      pulse_reset();
      win_ready = 1; npix = 48;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         run(1);
         found = dut.state == FETCH;
      end
      chk("e_reached_fetch", 96'(found), 96'(1));
      pix_valid = 0;
      rst_n = 0;
      #2;
      chk_reset_outs("e_rst");
      @(posedge clk); #1;
      rst_n = 1;
      clr_log();
      run(30);
      chk("e_no_win", 96'(wdat.size()), 96'(0));
      npix = 48;
      run(90);
      chk("e_win_count", 96'(wdat.size()), 96'(4));
      chk("e_first_win", wdat[0], FIRST_WIN);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
